amm_rw_arbiter: RTL and testbench

- Two-master to one-slave Avalon-MM arbiter in front of the EMIF controller's AMM port (user_clk domain).
- Master 0 is the AXI-Stream-to-AVMM write path (write-only, bursting). Master 1 is the readback/check path (read-only, bursting).
- Round-robin grant; write bursts are locked until the last beat is accepted. Outstanding read beats are credit-limited so the read return path is never over-subscribed.

---
 rtl/amm_arb_pkg.sv | 30 +++
 rtl/amm_rd_credit_tracker.sv | 57 +++++
 rtl/amm_rw_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_amm_rw_arbiter.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amm_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : amm_arb_pkg
//  Description : Shared types and helpers for the two-master AMM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package amm_arb_pkg;

    // Arbiter grant state; IDLE must stay at encoding 0 for reset.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_WR = 2'd1,
        GNT_RD = 2'd2
    } arb_state_t;

    // Side that most recently completed a grant.
    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } grant_t;

    localparam int LAT_W = 16;

    // Avalon burstcount of 0 is treated as a single beat.
    function automatic int unsigned eff_burst(input int unsigned burst);
        return (burst == 0) ? 1 : burst;
    endfunction

endpackage
`default_nettype wire

// File: rtl/amm_rd_credit_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : amm_rd_credit_tracker
//  Description : Counts read beats in flight and decides whether a new read
//                burst still fits inside the return-path budget.
//  Revision    : 1.0 - initial release
// ============================================================================
module amm_rd_credit_tracker
    import amm_arb_pkg::*;
#(
    parameter int BURST_W   = 7,
    parameter int MAX_OUTST = 64,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BURST_W-1:0] i_burst,
    input  logic               i_accept,
    input  logic               i_return,
    output logic [CNT_W-1:0]   o_outstanding,
    output logic               o_rd_ok
);

    // Wide enough to hold count + one full burst without wrapping.
    localparam int SUM_W = ((CNT_W > BURST_W) ? CNT_W : BURST_W) + 2;
    localparam logic [SUM_W-1:0] c_max = SUM_W'(MAX_OUTST);
    localparam logic [SUM_W-1:0] c_one = SUM_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] w_eff;
    logic [SUM_W-1:0] w_cur;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_dec;
    logic [SUM_W-1:0] w_next;

    assign w_eff   = SUM_W'(eff_burst(32'(i_burst)));
    assign w_cur   = SUM_W'(r_cnt);
    assign o_rd_ok = (w_cur + w_eff) <= c_max;

    // A return against an empty counter (stray beat after reset) is dropped.
    assign w_sum  = i_accept ? (w_cur + w_eff) : w_cur;
    assign w_dec  = (i_return && (w_sum != '0)) ? (w_sum - c_one) : w_sum;
    assign w_next = (w_dec > c_max) ? c_max : w_dec;

    assign o_outstanding = r_cnt;

    // Outstanding-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next[CNT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/amm_rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : amm_rw_arbiter
//  Description : Round-robin arbiter between a bursting write master (m0) and
//                a bursting read master (m1) in front of the EMIF AMM port.
//                Write bursts are locked; read beats are credit-limited.
//                Optional read-latency monitor: define AMM_ARB_LAT_MON_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module amm_rw_arbiter
    import amm_arb_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 27,
    parameter int BURST_W   = 7,
    parameter int BE_W      = DATA_W / 8,
    parameter int MAX_OUTST = 64
) (
    input  logic                             user_clk,
    input  logic                             user_reset,
    input  logic                             m0_write,
    input  logic [ADDR_W-1:0]                m0_address,
    input  logic [DATA_W-1:0]                m0_writedata,
    input  logic [BE_W-1:0]                  m0_byteenable,
    input  logic [BURST_W-1:0]               m0_burstcount,
    output logic                             m0_ready,
    input  logic                             m1_read,
    input  logic [ADDR_W-1:0]                m1_address,
    input  logic [BURST_W-1:0]               m1_burstcount,
    output logic                             m1_ready,
    output logic [DATA_W-1:0]                m1_readdata,
    output logic                             m1_readdatavalid,
    input  logic                             amm_ready,
    output logic                             amm_write,
    output logic                             amm_read,
    output logic [ADDR_W-1:0]                amm_address,
    output logic [DATA_W-1:0]                amm_writedata,
    output logic [BE_W-1:0]                  amm_byteenable,
    output logic [BURST_W-1:0]               amm_burstcount,
    input  logic [DATA_W-1:0]                amm_readdata,
    input  logic                             amm_readdatavalid,
    output logic [$clog2(MAX_OUTST+1)-1:0]   rd_outstanding,
    output logic                             busy
`ifdef AMM_ARB_LAT_MON_EN
    ,
    output logic [LAT_W-1:0]                 lat_last,
    output logic [LAT_W-1:0]                 lat_max
`endif
);

    localparam logic [BURST_W:0] c_one = (BURST_W+1)'(1);

    arb_state_t       r_state,        w_state_next;
    grant_t           r_last_grant,   w_last_grant_next;
    logic [BURST_W:0] r_beats_left,   w_beats_left_next;
    logic             r_started,      w_started_next;

    logic             w_credit_ok;
    logic             w_rd_ok;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [BURST_W:0] w_m0_eff;
    logic [BURST_W:0] w_remaining;

    assign w_m0_eff    = (BURST_W+1)'(eff_burst(32'(m0_burstcount)));
    // Beats still owed after the one being accepted this cycle.
    assign w_remaining = r_started ? (r_beats_left - c_one) : (w_m0_eff - c_one);

    assign w_wr_acc = (r_state == GNT_WR) && m0_write && amm_ready;
    assign w_rd_acc = (r_state == GNT_RD) && m1_read && amm_ready;
    assign w_rd_ok  = m1_read && w_credit_ok;

    assign m1_readdata      = amm_readdata;
    assign m1_readdatavalid = amm_readdatavalid;
    assign busy             = (r_state != IDLE);

    amm_rd_credit_tracker #(
        .BURST_W   (BURST_W),
        .MAX_OUTST (MAX_OUTST)
    ) u_credit (
        .clk           (user_clk),
        .rst           (user_reset),
        .i_burst       (m1_burstcount),
        .i_accept      (w_rd_acc),
        .i_return      (amm_readdatavalid),
        .o_outstanding (rd_outstanding),
        .o_rd_ok       (w_credit_ok)
    );

    // Grant state and write-burst bookkeeping registers.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_state      <= IDLE;
            r_last_grant <= RD;
            r_beats_left <= '0;
            r_started    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_beats_left <= w_beats_left_next;
            r_started    <= w_started_next;
        end
    end

    // Next-state arbitration and per-state bus steering.
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_beats_left_next = r_beats_left;
        w_started_next    = r_started;
        amm_write         = 1'b0;
        amm_read          = 1'b0;
        amm_address       = '0;
        amm_writedata     = '0;
        amm_byteenable    = '0;
        amm_burstcount    = '0;
        m0_ready          = 1'b0;
        m1_ready          = 1'b0;

        case (r_state)
            IDLE: begin
                w_started_next    = 1'b0;
                w_beats_left_next = '0;
                if (m0_write && w_rd_ok) begin
                    w_state_next = (r_last_grant == WR) ? GNT_RD : GNT_WR;
                end else if (m0_write) begin
                    w_state_next = GNT_WR;
                end else if (w_rd_ok) begin
                    w_state_next = GNT_RD;
                end
            end

            GNT_WR: begin
                amm_write      = m0_write;
                amm_address    = m0_address;
                amm_writedata  = m0_writedata;
                amm_byteenable = m0_byteenable;
                amm_burstcount = m0_burstcount;
                m0_ready       = amm_ready;
                // Locked until the final beat; a gap in m0_write just idles the bus.
                if (w_wr_acc) begin
                    w_beats_left_next = w_remaining;
                    w_started_next    = 1'b1;
                    if (w_remaining == '0) begin
                        w_state_next      = IDLE;
                        w_last_grant_next = WR;
                        w_started_next    = 1'b0;
                    end
                end
            end

            GNT_RD: begin
                // Strobe follows m1_read so a withdrawn request never reaches
                // the EMIF and the credit count stays consistent.
                amm_read       = m1_read;
                amm_address    = m1_address;
                amm_burstcount = m1_burstcount;
                m1_ready       = amm_ready;
                if (!m1_read) begin
                    w_state_next = IDLE;
                end else if (amm_ready) begin
                    w_state_next      = IDLE;
                    w_last_grant_next = RD;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef AMM_ARB_LAT_MON_EN
    logic             r_lat_run;
    logic [LAT_W-1:0] r_lat_cnt;
    logic             w_lat_start;

    // Only time a read that starts from an empty pipe, so the next return is its own.
    assign w_lat_start = w_rd_acc && (rd_outstanding == '0);

    // Read command-to-first-data latency timer with last/max capture.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_lat_run <= 1'b0;
            r_lat_cnt <= '0;
            lat_last  <= '0;
            lat_max   <= '0;
        end else begin
            if (r_lat_run && amm_readdatavalid) begin
                r_lat_run <= 1'b0;
                lat_last  <= r_lat_cnt;
                if (r_lat_cnt > lat_max) begin
                    lat_max <= r_lat_cnt;
                end
            end else if (r_lat_run && (r_lat_cnt != {LAT_W{1'b1}})) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
            if (w_lat_start) begin
                r_lat_run <= 1'b1;
                r_lat_cnt <= LAT_W'(1);
            end
        end
    end
`else
    // Latency monitor not built: no timer state and no lat_* ports.
`endif

endmodule
`default_nettype wire

// File: tb/tb_amm_rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amm_rw_arbiter
//  Description : Directed self-checking bench for amm_rw_arbiter.
//                Latency-monitor scenario is built when AMM_ARB_LAT_MON_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_amm_rw_arbiter;

    localparam int DATA_W    = 128;
    localparam int ADDR_W    = 27;
    localparam int BURST_W   = 7;
    localparam int BE_W      = DATA_W / 8;
    localparam int MAX_OUTST = 64;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic                user_clk;
    logic                user_reset;
    logic                m0_write;
    logic [ADDR_W-1:0]   m0_address;
    logic [DATA_W-1:0]   m0_writedata;
    logic [BE_W-1:0]     m0_byteenable;
    logic [BURST_W-1:0]  m0_burstcount;
    logic                m0_ready;
    logic                m1_read;
    logic [ADDR_W-1:0]   m1_address;
    logic [BURST_W-1:0]  m1_burstcount;
    logic                m1_ready;
    logic [DATA_W-1:0]   m1_readdata;
    logic                m1_readdatavalid;
    logic                amm_ready;
    logic                amm_write;
    logic                amm_read;
    logic [ADDR_W-1:0]   amm_address;
    logic [DATA_W-1:0]   amm_writedata;
    logic [BE_W-1:0]     amm_byteenable;
    logic [BURST_W-1:0]  amm_burstcount;
    logic [DATA_W-1:0]   amm_readdata;
    logic                amm_readdatavalid;
    logic [CNT_W-1:0]    rd_outstanding;
    logic                busy;
`ifdef AMM_ARB_LAT_MON_EN
    logic [15:0]         lat_last;
    logic [15:0]         lat_max;
`endif

    int checks = 0;
    int passed = 0;

    amm_rw_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BURST_W   (BURST_W),
        .BE_W      (BE_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .user_clk          (user_clk),
        .user_reset        (user_reset),
        .m0_write          (m0_write),
        .m0_address        (m0_address),
        .m0_writedata      (m0_writedata),
        .m0_byteenable     (m0_byteenable),
        .m0_burstcount     (m0_burstcount),
        .m0_ready          (m0_ready),
        .m1_read           (m1_read),
        .m1_address        (m1_address),
        .m1_burstcount     (m1_burstcount),
        .m1_ready          (m1_ready),
        .m1_readdata       (m1_readdata),
        .m1_readdatavalid  (m1_readdatavalid),
        .amm_ready         (amm_ready),
        .amm_write         (amm_write),
        .amm_read          (amm_read),
        .amm_address       (amm_address),
        .amm_writedata     (amm_writedata),
        .amm_byteenable    (amm_byteenable),
        .amm_burstcount    (amm_burstcount),
        .amm_readdata      (amm_readdata),
        .amm_readdatavalid (amm_readdatavalid),
        .rd_outstanding    (rd_outstanding),
        .busy              (busy)
`ifdef AMM_ARB_LAT_MON_EN
        ,
        .lat_last          (lat_last),
        .lat_max           (lat_max)
`endif
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    // Advance one clock; leave time just past the rising edge.
    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_write          = 1'b0;
        m0_address        = '0;
        m0_writedata      = '0;
        m0_byteenable     = '0;
        m0_burstcount     = '0;
        m1_read           = 1'b0;
        m1_address        = '0;
        m1_burstcount     = '0;
        amm_ready         = 1'b0;
        amm_readdata      = '0;
        amm_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        user_reset = 1'b1;
        m0_write   = 1'b1;
        m1_read    = 1'b1;
        amm_ready  = 1'b1;
        #1;
        checks++;
        if ({amm_write, amm_read, m0_ready, m1_ready, busy} !== 5'b0)
            $display("FAIL reset_strobes: got %b exp 00000",
                     {amm_write, amm_read, m0_ready, m1_ready, busy});
        else passed++;
        checks++;
        if (rd_outstanding !== '0 || amm_address !== '0 || amm_burstcount !== '0)
            $display("FAIL reset_buses: outst %0d addr %h burst %0d exp 0/0/0",
                     rd_outstanding, amm_address, amm_burstcount);
        else passed++;
        step();
        step();
        clear_inputs();
        user_reset = 1'b0;
        // Stray return with nothing outstanding: passthrough, counter floors at 0.
        amm_readdata      = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
        amm_readdatavalid = 1'b1;
        #1;
        checks++;
        if (m1_readdatavalid !== 1'b1 || m1_readdata !== 128'h0123_4567_89ab_cdef_0011_2233_4455_6677)
            $display("FAIL rd_passthrough: valid %b data %h exp 1 0123456789abcdef0011223344556677",
                     m1_readdatavalid, m1_readdata);
        else passed++;
        step();
        amm_readdatavalid = 1'b0;
        #1;
        checks++;
        if (rd_outstanding !== '0)
            $display("FAIL stray_return_floor: got %0d exp 0", rd_outstanding);
        else passed++;
    endtask

    task automatic test_single_write();
        m0_address    = 27'h100;
        m0_burstcount = 7'd4;
        m0_byteenable = '1;
        m0_writedata  = '0;
        m0_write      = 1'b1;
        amm_ready     = 1'b1;
        #1;
        checks++;
        if (amm_write !== 1'b0)
            $display("FAIL wr_grant_latency: amm_write %b exp 0", amm_write);
        else passed++;
        step();
        for (int i = 0; i < 4; i++) begin
            m0_writedata = DATA_W'(i + 1);
            #1;
            checks++;
            if ({amm_write, m0_ready, m1_ready, busy} !== 4'b1101)
                $display("FAIL wr_beat%0d_strobes: got %b exp 1101", i,
                         {amm_write, m0_ready, m1_ready, busy});
            else passed++;
            checks++;
            if (amm_writedata !== DATA_W'(i + 1) || amm_address !== 27'h100 || amm_burstcount !== 7'd4)
                $display("FAIL wr_beat%0d_bus: data %0h addr %h burst %0d exp %0d/100/4", i,
                         amm_writedata, amm_address, amm_burstcount, i + 1);
            else passed++;
            step();
        end
        m0_write = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || amm_write !== 1'b0)
            $display("FAIL wr_done_idle: busy %b amm_write %b exp 0 0", busy, amm_write);
        else passed++;
        // Last grant was WR, so with both requesting the read side wins next.
        m0_write      = 1'b1;
        m1_read       = 1'b1;
        m1_burstcount = 7'd1;
        step();
        checks++;
        if ({amm_read, amm_write, m0_ready} !== 3'b100)
            $display("FAIL rr_after_write: rd/wr/m0rdy %b exp 100", {amm_read, amm_write, m0_ready});
        else passed++;
        m0_write = 1'b0;
        step();
        m1_read           = 1'b0;
        amm_readdatavalid = 1'b1;
        #1;
        checks++;
        if (rd_outstanding !== 7'd1)
            $display("FAIL rd_count_one: got %0d exp 1", rd_outstanding);
        else passed++;
        step();
        amm_readdatavalid = 1'b0;
        #1;
        checks++;
        if (rd_outstanding !== 7'd0)
            $display("FAIL rd_count_drain: got %0d exp 0", rd_outstanding);
        else passed++;
    endtask

    task automatic test_alternate();
        logic [9:0] exp_w;
        logic [9:0] exp_r;
        exp_w = 10'b0001100011;
        exp_r = 10'b0100001000;
        do_reset();
        m0_burstcount = 7'd2;
        m1_burstcount = 7'd8;
        m0_write      = 1'b1;
        m1_read       = 1'b1;
        amm_ready     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({amm_write, amm_read, m0_ready, m1_ready} !== {exp_w[i], exp_r[i], exp_w[i], exp_r[i]})
                $display("FAIL alt_cycle%0d: wr/rd/m0rdy/m1rdy %b exp %b", i + 1,
                         {amm_write, amm_read, m0_ready, m1_ready},
                         {exp_w[i], exp_r[i], exp_w[i], exp_r[i]});
            else passed++;
        end
        m0_write = 1'b0;
        m1_read  = 1'b0;
        #1;
        checks++;
        if (rd_outstanding !== 7'd16)
            $display("FAIL alt_outstanding: got %0d exp 16", rd_outstanding);
        else passed++;
        step();
    endtask

    task automatic test_stall();
        logic [8:0] wr_pat;
        logic [8:0] rdy_pat;
        int         beats;
        logic       leak;
        logic       wr_bad;
        wr_pat  = 9'b110011111;
        rdy_pat = 9'b111110001;
        beats   = 0;
        leak    = 1'b0;
        wr_bad  = 1'b0;
        do_reset();
        m0_address    = 27'h200;
        m0_burstcount = 7'd4;
        m0_byteenable = '1;
        m1_burstcount = 7'd1;
        m0_write      = 1'b1;
        m1_read       = 1'b1;
        amm_ready     = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            m0_write  = wr_pat[i];
            amm_ready = rdy_pat[i];
            #1;
            if (amm_write && amm_ready) beats++;
            if (amm_read || m1_ready) leak = 1'b1;
            if (amm_write !== wr_pat[i]) wr_bad = 1'b1;
            step();
        end
        m0_write  = 1'b0;
        amm_ready = 1'b1;
        #1;
        checks++;
        if (beats !== 4)
            $display("FAIL stall_beats: got %0d exp 4", beats);
        else passed++;
        checks++;
        if (leak !== 1'b0 || wr_bad !== 1'b0)
            $display("FAIL stall_lock: read_leak %b write_follow_err %b exp 0 0", leak, wr_bad);
        else passed++;
        checks++;
        if (busy !== 1'b0 || amm_read !== 1'b0)
            $display("FAIL stall_end_idle: busy %b amm_read %b exp 0 0", busy, amm_read);
        else passed++;
        step();
        checks++;
        if (amm_read !== 1'b1 || m1_ready !== 1'b1)
            $display("FAIL stall_read_after: amm_read %b m1_ready %b exp 1 1", amm_read, m1_ready);
        else passed++;
        step();
        m1_read = 1'b0;
    endtask

    task automatic test_credit();
        int   nreads;
        logic held_bad;
        nreads   = 0;
        held_bad = 1'b0;
        do_reset();
        m1_burstcount = 7'd8;
        m1_read       = 1'b1;
        amm_ready     = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (amm_read) nreads++;
        end
        checks++;
        if (nreads !== 8 || rd_outstanding !== 7'd64)
            $display("FAIL credit_fill: reads %0d outst %0d exp 8 64", nreads, rd_outstanding);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (amm_read) held_bad = 1'b1;
        end
        checks++;
        if (held_bad !== 1'b0)
            $display("FAIL credit_hold_full: amm_read seen %b exp 0", held_bad);
        else passed++;
        amm_readdatavalid = 1'b1;
        step();
        amm_readdatavalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (amm_read) held_bad = 1'b1;
            step();
        end
        checks++;
        if (held_bad !== 1'b0 || rd_outstanding !== 7'd63)
            $display("FAIL credit_hold_63: read_seen %b outst %0d exp 0 63", held_bad, rd_outstanding);
        else passed++;
        amm_readdatavalid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (amm_read) held_bad = 1'b1;
        end
        amm_readdatavalid = 1'b0;
        #1;
        checks++;
        if (held_bad !== 1'b0 || amm_read !== 1'b0 || rd_outstanding !== 7'd56)
            $display("FAIL credit_drain_56: read_seen %b amm_read %b outst %0d exp 0 0 56",
                     held_bad, amm_read, rd_outstanding);
        else passed++;
        step();
        checks++;
        if (amm_read !== 1'b1)
            $display("FAIL credit_regrant: amm_read %b exp 1", amm_read);
        else passed++;
        step();
        m1_read = 1'b0;
        #1;
        checks++;
        if (rd_outstanding !== 7'd64)
            $display("FAIL credit_refill: got %0d exp 64", rd_outstanding);
        else passed++;
    endtask

    task automatic test_accept_return_and_reset();
        do_reset();
        m1_burstcount = 7'd0;
        m1_read       = 1'b1;
        amm_ready     = 1'b1;
        step();
        checks++;
        if (amm_read !== 1'b1 || amm_burstcount !== 7'd0)
            $display("FAIL burst0_forward: amm_read %b burst %0d exp 1 0", amm_read, amm_burstcount);
        else passed++;
        step();
        m1_burstcount = 7'd9;
        #1;
        checks++;
        if (rd_outstanding !== 7'd1)
            $display("FAIL burst0_credit: got %0d exp 1", rd_outstanding);
        else passed++;
        step();
        step();
        m1_burstcount = 7'd4;
        #1;
        checks++;
        if (rd_outstanding !== 7'd10)
            $display("FAIL outst_10: got %0d exp 10", rd_outstanding);
        else passed++;
        step();
        amm_readdatavalid = 1'b1;
        step();
        m1_read           = 1'b0;
        amm_readdatavalid = 1'b0;
        #1;
        checks++;
        if (rd_outstanding !== 7'd13)
            $display("FAIL accept_with_return: got %0d exp 13", rd_outstanding);
        else passed++;
        // Reset in the middle of a write burst.
        m0_burstcount = 7'd4;
        m0_write      = 1'b1;
        step();
        step();
        user_reset = 1'b1;
        #1;
        checks++;
        if ({amm_write, m0_ready, busy} !== 3'b000 || rd_outstanding !== 7'd0)
            $display("FAIL reset_mid_burst: wr/m0rdy/busy %b outst %0d exp 000 0",
                     {amm_write, m0_ready, busy}, rd_outstanding);
        else passed++;
        step();
        m0_write   = 1'b0;
        user_reset = 1'b0;
        step();
    endtask

`ifdef AMM_ARB_LAT_MON_EN
    task automatic test_latency();
        do_reset();
        m1_burstcount = 7'd1;
        m1_read       = 1'b1;
        amm_ready     = 1'b1;
        step();
        step();
        m1_read = 1'b0;
        for (int i = 0; i < 22; i++) step();
        amm_readdatavalid = 1'b1;
        step();
        amm_readdatavalid = 1'b0;
        #1;
        checks++;
        if (lat_last !== 16'd23 || lat_max !== 16'd23)
            $display("FAIL lat_first: last %0d max %0d exp 23 23", lat_last, lat_max);
        else passed++;
        m1_read = 1'b1;
        step();
        step();
        m1_read = 1'b0;
        for (int i = 0; i < 16; i++) step();
        amm_readdatavalid = 1'b1;
        step();
        amm_readdatavalid = 1'b0;
        #1;
        checks++;
        if (lat_last !== 16'd17 || lat_max !== 16'd23)
            $display("FAIL lat_second: last %0d max %0d exp 17 23", lat_last, lat_max);
        else passed++;
    endtask
`endif

    initial begin
        clear_inputs();
        user_reset = 1'b1;
        test_reset();
        test_single_write();
        test_alternate();
        test_stall();
        test_credit();
        test_accept_return_and_reset();
`ifdef AMM_ARB_LAT_MON_EN
        test_latency();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
